sdp_ram_stream_reader: RTL
==========================

# sdp_ram_stream_reader

- Read-side streaming controller for the team's simple dual-port block RAM.
- Takes a (base address, length) command and issues consecutive reads on the RAM read port.
- Absorbs the RAM's fixed read latency with an internal skid FIFO and presents the words as a valid/ready stream with a last marker.
- Sits between the RAM read port and downstream compute/DMA logic, all on the RAM read clock.

## Interface
Parameters:
- RAM_WIDTH, 36, data word width; must match the RAM instance.
- RAM_DEPTH, 512, RAM entries; ADDR_W = clog2(RAM_DEPTH).
- RD_LATENCY, 2, RAM read latency in cycles: 1 = low-latency RAM, 2 = output-registered RAM.

Ports:
- clka  in  1  clock; drives the RAM read clock.
- rstb  in  1  synchronous, active-high reset.
- start  in  1  command strobe; sampled in IDLE only.
- base_addr  in  ADDR_W  first read address.
- length  in  ADDR_W+1  number of words, 0..RAM_DEPTH.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the command completes.
- err  out  1  one-cycle pulse with done on a rejected command.
- ram_addrb  out  ADDR_W  RAM read address.
- ram_enb  out  1  RAM read enable; one read per high cycle.
- ram_regceb  out  1  RAM output-register enable; constant 1.
- ram_rstb  out  1  RAM output reset; equals rstb.
- ram_doutb  in  RAM_WIDTH  RAM read data.
- m_data  out  RAM_WIDTH  stream data.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- m_last  out  1  high with the final word of a command.

## Operation
State machine: IDLE -> RUN -> DRAIN -> IDLE.
- **IDLE:** start=1 with length>0 (and in range, see Configuration) latches base_addr and length, then goes to RUN. start with length=0 pulses done next cycle, with no reads, and stays in IDLE. start in RUN or DRAIN is ignored.
- **RUN:**
  - ram_enb=1 when issue credit is available; credit = (in_flight + fifo_count) < FIFO_DEPTH, with FIFO_DEPTH = RD_LATENCY+2.
  - Each issue increments ram_addrb and decrements the remaining count.
  - When the last read issues, go to DRAIN.
- **DRAIN:**
  - When the final word is accepted (m_valid & m_ready & m_last), pulse done and return to IDLE.
- **Latency tracking:** an RD_LATENCY-deep valid shift register tracks in-flight reads. When a tag exits, ram_doutb is written into the FIFO; credit guarantees the FIFO never overflows.
- **Stream:** m_data and m_valid come from the FIFO head. A word pops on m_valid & m_ready. m_last is tagged on the word of the final issued read.
- **Backpressure:** m_data, m_last and m_valid hold while m_valid=1 and m_ready=0; issue stalls only via credit.
- **Reset** (including mid-command): state IDLE, FIFO and in-flight tags cleared (in-flight RAM data discarded), remaining count 0.
- **Outputs after reset:** busy, done, err, ram_enb, m_valid, m_last = 0; ram_addrb = 0.

## Timing
- start sampled at cycle 0 → busy=1 and first ram_enb=1 at cycle 1.
- RAM data is written into the FIFO at the end of cycle 1+RD_LATENCY; first m_valid=1 at cycle 2+RD_LATENCY (cycle 4 when RD_LATENCY=2).
- Throughput with m_ready held high: one word per cycle, no bubbles after the first word.
- done is asserted the cycle after the last handshake; busy falls in the same cycle.
- A new start is accepted in the cycle after done.

## Configuration
- SDP_RD_WRAP_EN defined: addresses wrap from RAM_DEPTH-1 to 0 (circular buffer); err is constant 0.
- SDP_RD_WRAP_EN undefined: a start with base_addr+length > RAM_DEPTH is rejected. done=1 and err=1 the next cycle, no reads are issued, and the block stays IDLE.
- The length=0 case is unaffected by the macro.

## Test plan
- RAM preloaded with mem[i]=i, base=0, length=8, m_ready=1 → m_data 0..7 on consecutive cycles from cycle 4; m_last with 7; done one cycle after the last handshake.
- base=10, length=6, m_ready toggling 1,0 each cycle → words 10..15 in order, none lost or duplicated, data stable while stalled; in_flight+fifo_count never exceeds 4.
- WRAP_EN defined: base=510, length=4 → data 510, 511, 0, 1; err=0. WRAP_EN undefined: same command → done=1, err=1 at cycle 1, ram_enb never asserted.
- length=0 → done pulse at cycle 1, busy stays 0, no m_valid.
- rstb asserted mid-command after 3 words → next cycle m_valid=0, busy=0, ram_enb=0; a new command base=0, length=2 then returns 0, 1 with no stale data.
- RD_LATENCY=1, base=0, length=4, m_ready=1 → first m_valid at cycle 3, words 0..3 back to back.

Source files
------------

// File: rtl/sdp_ram_stream_reader.sv
// Streams a (base, length) block out of a simple dual-port RAM read port as a valid/ready stream.
// Optional macro SDP_RD_WRAP_EN: wrap addresses circularly instead of rejecting out-of-range commands.
module sdp_ram_stream_reader #(
  parameter int RAM_WIDTH  = 36,
  parameter int RAM_DEPTH  = 512,
  parameter int RD_LATENCY = 2,
  localparam int ADDR_W    = $clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 start,
  input  logic [ADDR_W-1:0]    base_addr,
  input  logic [ADDR_W:0]      length,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [ADDR_W-1:0]    ram_addrb,
  output logic                 ram_enb,
  output logic                 ram_regceb,
  output logic                 ram_rstb,
  input  logic [RAM_WIDTH-1:0] ram_doutb,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [1:0]           dbg_state
);

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  state_t                 state, state_nxt;
  logic [ADDR_W-1:0]      addr, addr_inc;
  logic [ADDR_W:0]        remaining;
  logic [RD_LATENCY-1:0]  tag_v, tag_last;
  logic [RAM_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0]  fifo_last;
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;
  logic [CNT_W:0]         in_flight;
  logic                   credit, issue, last_issue, fifo_wr, pop, finish;
  logic                   accept, reject, zero_len, out_of_range;
  logic                   done_q;

  // Stream handshake: a word transfers on a cycle where m_valid & m_ready;
  // while m_valid=1 and m_ready=0 the word (data, last) is held unchanged.
  assign m_valid    = (count != '0);
  assign m_data     = fifo_data[rd_ptr];
  assign m_last     = m_valid & fifo_last[rd_ptr];
  assign pop        = m_valid & m_ready;
  assign fifo_wr    = tag_v[RD_LATENCY-1];

  assign ram_addrb  = addr;
  assign ram_enb    = issue;
  assign ram_regceb = 1'b1;
  assign ram_rstb   = rstb;
  assign busy       = (state != IDLE);
  assign done       = done_q;
  assign dbg_state  = state;

  // Reads still inside the RAM pipeline count against FIFO space.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      in_flight = in_flight + {{CNT_W{1'b0}}, tag_v[i]};
    end
  end

  assign credit     = (in_flight + {1'b0, count}) < (CNT_W+1)'(FIFO_DEPTH);
  assign issue      = (state == RUN) && credit;
  assign last_issue = issue && (remaining == (ADDR_W+1)'(1));
  assign finish     = (state == DRAIN) && pop && m_last;
  assign addr_inc   = (addr == ADDR_W'(RAM_DEPTH - 1)) ? '0 : addr + ADDR_W'(1);

`ifdef SDP_RD_WRAP_EN
  assign out_of_range = 1'b0;
  assign err          = 1'b0;
`else
  logic err_q;
  assign out_of_range = ({2'b00, base_addr} + {1'b0, length}) > (ADDR_W+2)'(RAM_DEPTH);
  assign err          = err_q;

  always_ff @(posedge clka) begin
    if (rstb) err_q <= 1'b0;
    else      err_q <= reject;
  end
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    zero_len  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (length == '0) begin
            zero_len = 1'b1;
          end else if (out_of_range) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = RUN;
          end
        end
      end
      RUN:     if (last_issue) state_nxt = DRAIN;
      DRAIN:   if (finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      tag_v     <= '0;
      tag_last  <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= zero_len | reject | finish;
      if (accept) begin
        addr      <= base_addr;
        remaining <= length;
      end else if (issue) begin
        addr      <= addr_inc;
        remaining <= remaining - (ADDR_W+1)'(1);
      end
      tag_v[0]    <= issue;
      tag_last[0] <= last_issue;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i]    <= tag_v[i-1];
        tag_last[i] <= tag_last[i-1];
      end
    end
  end

  // Skid FIFO; credit keeps occupancy at or below FIFO_DEPTH.
  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      fifo_last <= '0;
    end else begin
      if (fifo_wr) begin
        fifo_last[wr_ptr] <= tag_last[RD_LATENCY-1];
        wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      end
      case ({fifo_wr, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clka) begin
    if (fifo_wr) fifo_data[wr_ptr] <= ram_doutb;
  end

endmodule
